bcd_display_scan: RTL and testbench
===================================

# bcd_display_scan

Multiplexed 4-digit 7-segment display driver for the BCD hours/minutes clock. Consumes the four BCD digits produced by the clock counter and scans them one at a time onto a common-anode/cathode display. Blinks the hour/minute colon. Takes a consistent snapshot of all four digits once per frame so a ripple-carry update mid-scan never shows torn time.

## Interface
- `SCAN_DIV`, 50000: clock cycles each digit is lit; must be ≥ 2.
- `BLINK_FRAMES`, 250: full frames per colon blink half-period; must be ≥ 1.
- `SEG_ACTIVE_LOW`, 1: 1 = segments driven low-true; 0 = high-true.
- `AN_ACTIVE_LOW`, 1: 1 = digit enables driven low-true; 0 = high-true.
- `clk` in 1: single clock; rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ms_hour` in 4: BCD tens of hours.
- `ls_hour` in 4: BCD units of hours.
- `ms_min` in 4: BCD tens of minutes.
- `ls_min` in 4: BCD units of minutes.
- `seg` out 7: `{g,f,e,d,c,b,a}` segment drive, polarity per `SEG_ACTIVE_LOW`.
- `dp` out 1: decimal point (colon), polarity per `SEG_ACTIVE_LOW`.
- `an` out 4: digit enables, one-hot when lit; `an[3]` = `ms_hour` (leftmost) … `an[0]` = `ls_min`.
- `frame_start` out 1: one-cycle pulse on the edge the snapshot is taken.

## Operation
- Prescaler counts 0..`SCAN_DIV`-1 and wraps. `tick` = prescaler == `SCAN_DIV`-1.
- Digit index: 2-bit state. Scan order is 3→2→1→0→3. Each step advances on `tick`.
- Entering index 3 starts a frame:
  - Snapshot `{ms_hour, ls_hour, ms_min, ls_min}` into internal registers.
  - Pulse `frame_start`.
  - Drive digit 3 from the incoming `ms_hour`, not the stale snapshot.
- Indices 2..0 display snapshot values only. Input changes mid-frame are ignored until the next frame.
- Decode, logical (active-high) values:
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110.
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111.
  - Codes 10–15 show a dash: 1000000.
- Polarity is applied after decode: invert when `*_ACTIVE_LOW` = 1.
- Colon:
  - `dp` is lit only while index = 2 (`ls_hour`) and the blink phase = 1.
  - Blink phase toggles after every `BLINK_FRAMES` completed frames.
  - The blink frame counter increments on `frame_start`.
- Reset values (all asynchronous on `reset_n` low):
  - Prescaler 0, index 0, snapshot 0, blink phase 0, blink counter 0.
  - `an` all inactive, `seg` all off, `dp` off, `frame_start` 0.
- Reset asserted mid-frame blanks the display immediately. After release, the display stays blank until the first `tick`, which enters index 3.

## Timing
- `seg`, `dp`, `an`, `frame_start` are registered and update on the `tick` edge. No combinational path from inputs to outputs.
- Each digit is lit for exactly `SCAN_DIV` cycles. Frame period is 4×`SCAN_DIV`.
- First lit digit appears `SCAN_DIV` cycles after `reset_n` rises (index 3, `ms_hour`).
- Input-to-display latency: at most 4×`SCAN_DIV` cycles; 0 extra cycles for `ms_hour` at the frame edge.
- Colon full period: 2×`BLINK_FRAMES`×4×`SCAN_DIV` cycles.
- Only one `an` bit is active at any time. On a digit change, `an` and `seg` switch on the same edge.

## Configuration
- `BCD_SCAN_LZB_EN` defined: leading-zero blanking. When the digit-3 value is 0, `seg` is all off for index 3. `an[3]` still asserts, so timing is unchanged.
- Not defined: `ms_hour` = 0 displays "0" (0111111 logical).

## Structure
- Package `bcd_disp_pkg` holds:
  - the `digit_idx_t` 2-bit typedef;
  - segment constants `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_BLANK`.
- Sub-module `bcd_to_seg7`: purely combinational 4-bit → 7-bit logical decode, instantiated once on the muxed digit.

## Test plan
- **Reset release.** `SCAN_DIV`=4. Inputs 1,2,3,4. Hold `reset_n` low, then release.
  - `an` inactive and `seg` off for 4 cycles.
  - Then `an`=0111 (active-low), `seg` = ~0000110, `frame_start` pulses once.
- **Full scan.** Continue the reset-release case for 16 cycles.
  - `an` sequence 0111, 1011, 1101, 1110, 4 cycles each.
  - `seg` logical sequence 0000110, 1011011, 1001111, 1100110.
- **Snapshot.** Change `ls_min` from 4 to 9 while index = 2.
  - Index 0 still shows 4 (1100110).
  - The next frame shows 9 (1101111).
- **Invalid BCD.** `ms_min`=4'hC → index 1 shows dash 1000000.
  - With `BCD_SCAN_LZB_EN` defined and `ms_hour`=0: index 3 has `seg` all off and `an[3]` active.
  - Without the macro, the same input shows 0111111.
- **Colon blink.** `BLINK_FRAMES`=2.
  - `dp` off during frames 1–2, lit during index 2 of frames 3–4, off again in frames 5–6.
  - `dp` is never lit on indices 3, 1, 0.
- **Reset mid-frame.** Pull `reset_n` low at index 1, cycle 2.
  - Outputs blank in the same cycle with no clock edge.
  - After release, the first frame restarts at index 3 with the blink phase back at 0.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared types and segment encodings for the BCD display scanner.
// Segment vectors are logical (1 = lit), ordered {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_idx_t;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to logical 7-segment decode; non-BCD codes show a dash.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed 4-digit 7-segment scanner with per-frame digit snapshot and blinking colon.
// Define BCD_SCAN_LZB_EN to blank a zero in the tens-of-hours digit (its enable still asserts).
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned BLINK_FRAMES   = 250,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
)
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] ms_hour,
    input  logic [3:0] ls_hour,
    input  logic [3:0] ms_min,
    input  logic [3:0] ls_min,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int unsigned CNT_W   = $clog2(SCAN_DIV);
    localparam int unsigned BLK_W   = $clog2(BLINK_FRAMES + 1);
    localparam logic [6:0]  SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [3:0]  AN_OFF  = {4{AN_ACTIVE_LOW}};

    logic [CNT_W-1:0] presc_q, presc_d;
    logic             tick;
    digit_idx_t       idx_q, idx_d;
    logic [15:0]      snap_q, snap_d;
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             phase_q, phase_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       an_q, an_d;
    logic             fs_q, fs_d;
    logic [3:0]       digit_mux;
    logic [6:0]       seg_logic;
    logic [6:0]       seg_shown;

    assign tick = (presc_q == CNT_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q <= DIG0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // Scan runs 3->2->1->0->3; from reset index 0 the first tick lands on 3.
    always_comb begin
        idx_d = idx_q;
        if (tick) begin
            idx_d = digit_idx_t'(idx_q - 2'd1);
        end
    end

    // Digit 3 comes straight from the input so it matches the snapshot taken on the same edge.
    always_comb begin
        digit_mux = ms_hour;
        case (idx_d)
            DIG3:    digit_mux = ms_hour;
            DIG2:    digit_mux = snap_q[11:8];
            DIG1:    digit_mux = snap_q[7:4];
            DIG0:    digit_mux = snap_q[3:0];
            default: digit_mux = ms_hour;
        endcase
    end

    bcd_to_seg7 u_decode (
        .bcd_i (digit_mux),
        .seg_o (seg_logic)
    );

    always_comb begin
        seg_shown = seg_logic;
`ifdef BCD_SCAN_LZB_EN
        if ((idx_d == DIG3) && (digit_mux == 4'd0)) begin
            seg_shown = SEG_BLANK;
        end
`endif
        seg_d = seg_q;
        an_d  = an_q;
        dp_d  = dp_q;
        fs_d  = 1'b0;
        if (tick) begin
            seg_d = seg_shown ^ {7{SEG_ACTIVE_LOW}};
            an_d  = (4'b0001 << idx_d) ^ {4{AN_ACTIVE_LOW}};
            dp_d  = ((idx_d == DIG2) && phase_q) ^ SEG_ACTIVE_LOW;
            fs_d  = (idx_d == DIG3);
        end
    end

    // A frame_start marks the beginning of a frame, so the count reaching BLINK_FRAMES
    // here means that many frames have fully completed.
    always_comb begin
        presc_d     = tick ? '0 : presc_q + 1'b1;
        snap_d      = snap_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (tick && (idx_d == DIG3)) begin
            snap_d = {ms_hour, ls_hour, ms_min, ls_min};
        end
        if (fs_q) begin
            if (blink_cnt_q == BLK_W'(BLINK_FRAMES)) begin
                blink_cnt_d = BLK_W'(1);
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q     <= '0;
            snap_q      <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            seg_q       <= SEG_OFF;
            dp_q        <= SEG_ACTIVE_LOW;
            an_q        <= AN_OFF;
            fs_q        <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            snap_q      <= snap_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
            fs_q        <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: frame-level reference model feeds a queue,
// a negedge monitor pops one entry per digit change and checks dwell time and hold stability.
module tb_bcd_display_scan;

    localparam int S  = 4;
    localparam int BF = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [3:0] ms_hour, ls_hour, ms_min, ls_min;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_start;

    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    bit   monEn      = 1'b0;
    exp_t expQ [$];

    logic [3:0] prevAn;
    logic [6:0] prevSeg;
    logic       prevDp;
    int         runLen;

    bcd_display_scan #(
        .SCAN_DIV       (S),
        .BLINK_FRAMES   (BF),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ms_hour     (ms_hour),
        .ls_hour     (ls_hour),
        .ms_min      (ms_min),
        .ls_min      (ls_min),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] segOf(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one frame's digits just before its frame edge and queue the four expected digits.
    task automatic applyStimulus(input int f, input logic [3:0] mh, input logic [3:0] lh,
                                 input logic [3:0] mm, input logic [3:0] lm);
        logic [3:0] vals [4];
        logic [6:0] lg;
        logic       phase;
        exp_t       e;
        ms_hour = mh;
        ls_hour = lh;
        ms_min  = mm;
        ls_min  = lm;
        vals[3] = mh;
        vals[2] = lh;
        vals[1] = mm;
        vals[0] = lm;
        phase   = ((f / BF) % 2) == 1;
        for (int p = 3; p >= 0; p--) begin
            lg = segOf(vals[p]);
`ifdef BCD_SCAN_LZB_EN
            if (p == 3 && vals[p] == 4'd0) lg = 7'b0000000;
`endif
            e.an  = ~(4'b0001 << p);
            e.seg = ~lg;
            e.dp  = !(p == 2 && phase);
            e.fs  = (p == 3);
            expQ.push_back(e);
        end
    endtask

    task automatic stepTo(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    function automatic logic [3:0] rndDigit();
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic runFrames(input int nf, input bit planned);
        int edgeCyc;
        int r;
        logic [3:0] mh;
        for (int f = 0; f < nf; f++) begin
            edgeCyc = S * (1 + 4 * f);
            stepTo(edgeCyc - 1);
            if (planned && f == 0) begin
                applyStimulus(f, 4'd1, 4'd2, 4'd3, 4'd4);
            end else if (planned && f == 1) begin
                applyStimulus(f, 4'd0, 4'd2, 4'hC, 4'd9);
            end else begin
                mh = ($urandom_range(0, 3) == 0) ? 4'd0 : rndDigit();
                applyStimulus(f, mh, rndDigit(), rndDigit(), rndDigit());
            end
            r = (planned && f == 0) ? S + 1 : int'($urandom_range(0, 4 * S - 2));
            stepTo(edgeCyc + r);
            if (planned && f == 0) begin
                ls_min = 4'd9;
            end else begin
                ms_hour = rndDigit();
                ls_hour = rndDigit();
                ms_min  = rndDigit();
                ls_min  = rndDigit();
            end
        end
    endtask

    task automatic checkBlank(input string name);
        checkOutput({name, "_an"},  {12'h0, an},          16'h000F);
        checkOutput({name, "_seg"}, {9'h0, seg},          16'h007F);
        checkOutput({name, "_dp"},  {15'h0, dp},          16'h0001);
        checkOutput({name, "_fs"},  {15'h0, frame_start}, 16'h0000);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!monEn) begin
            prevAn  = 4'hF;
            prevSeg = 7'h7F;
            prevDp  = 1'b1;
            runLen  = 0;
        end else if (an !== prevAn) begin
            checkOutput("dwell", 16'(runLen), 16'(S));
            if (expQ.size() == 0) begin
                checkOutput("queue_underflow", 16'(expQ.size()), 16'd1);
            end else begin
                e = expQ.pop_front();
                checkOutput("digit", {3'b0, an, seg, dp, frame_start}, {3'b0, e});
            end
            prevAn  = an;
            prevSeg = seg;
            prevDp  = dp;
            runLen  = 1;
        end else begin
            checkOutput("hold", {7'b0, seg, dp, frame_start}, {7'b0, prevSeg, prevDp, 1'b0});
            runLen++;
        end
    end

    initial begin
        reset_n = 1'b0;
        ms_hour = 4'd1;
        ls_hour = 4'd2;
        ms_min  = 4'd3;
        ls_min  = 4'd4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkBlank("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc     = 0;
        monEn   = 1'b1;

        runFrames(7, 1'b1);

        stepTo(S * (1 + 4 * 7) - 1);
        checkOutput("drain_a", 16'(expQ.size()), 16'd0);
        monEn = 1'b0;
        ms_hour = rndDigit();
        stepTo(S * (1 + 4 * 7 + 2) + 1);
        checkOutput("pre_reset_an", {12'h0, an}, 16'h000D);
        reset_n = 1'b0;
        #1;
        checkBlank("midreset");
        expQ.delete();
        repeat (2) @(posedge clk);
        #1;
        checkBlank("held_reset");
        reset_n = 1'b1;
        cyc     = 0;
        monEn   = 1'b1;

        runFrames(5, 1'b0);
        stepTo(S * 4 * 5 + 1);
        checkOutput("drain_b", 16'(expQ.size()), 16'd0);
        monEn = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
